// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter using reverse double-dabble,
// one shift/correct step per clock, with valid/ready on both sides.
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [4*DIGITS-1:0]   bcd_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [BIN_W-1:0]      bin_o,
  output logic                  err_o
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WORK_W-1:0] work_q, work_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              err_q, err_d;

  logic [WORK_W-1:0] shifted;
  logic [WORK_W-1:0] corrected;
  logic [DIGITS-1:0] digit_bad;

  // Working register is {bcd, bin}; the BCD LSB falls into the bin MSB.
  assign shifted = work_q >> 1;
  assign corrected[BIN_W-1:0] = shifted[BIN_W-1:0];

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_bad[gi] = bcd_i[4*gi +: 4] > 4'd9;
      // Each digit is corrected on its own; no borrow crosses digit fields.
      assign corrected[BIN_W + 4*gi +: 4] =
        (shifted[BIN_W + 4*gi +: 4] >= 4'd8) ? shifted[BIN_W + 4*gi +: 4] - 4'd3
                                              : shifted[BIN_W + 4*gi +: 4];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          if (|digit_bad) begin
            state_d = DONE;
            err_d   = 1'b1;
            bin_d   = '0;
          end else begin
            work_d  = {bcd_i, {BIN_W{1'b0}}};
            cnt_d   = CNT_W'(BIN_W);
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = corrected;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          bin_d   = shifted[BIN_W-1:0];
          err_d   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign bin_o       = bin_q;
  assign err_o       = err_q;

endmodule
